// File: rtl/interrupt_request_unit_pkg.sv
// rtl/interrupt_request_unit_pkg.sv - shared state encodings for the request unit and interrupt controller
package interrupt_request_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE       = 2'd0,
    CTRL_ISR_INIT   = 2'd1,
    CTRL_ISR_RUN    = 2'd2,
    CTRL_ISR_RETURN = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/interrupt_request_unit_if.sv
// rtl/interrupt_request_unit_if.sv - request/acknowledge handshake between request unit and interrupt controller
interface interrupt_request_unit_if #(
  parameter int ID_W = 3
);

  logic            interrupt_signal;
  logic [ID_W-1:0] irq_id;
  logic            isr_ack;
  logic            isr_done;

  modport master (
    output interrupt_signal,
    output irq_id,
    input  isr_ack,
    input  isr_done
  );

  modport slave (
    input  interrupt_signal,
    input  irq_id,
    output isr_ack,
    output isr_done
  );

endinterface

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchronizer followed by a rising-edge detector for one interrupt line
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/interrupt_request_unit.sv
// rtl/interrupt_request_unit.sv - latches interrupt edges as pending bits and requests the lowest enabled one
module interrupt_request_unit #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IRQ-1:0]       irq_in,
  input  logic                     mask_wr_en,
  input  logic [NUM_IRQ-1:0]       mask_wr_data,
  output logic [NUM_IRQ-1:0]       pending,
  output logic [NUM_IRQ-1:0]       irq_mask,
  interrupt_request_unit_if.master ctrl
);

  import interrupt_request_unit_pkg::*;

  irq_state_t         state;
  irq_state_t         state_next;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] clear;
  logic [ID_W-1:0]    lowest_id;
  logic [ID_W-1:0]    id_next;
  logic               signal_next;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .line  (irq_in[i]),
      .rise  (rise[i])
    );
  end

  assign active = pending & irq_mask;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    lowest_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) lowest_id = ID_W'(i);
    end
  end

  always_comb begin
    state_next  = state;
    signal_next = ctrl.interrupt_signal;
    id_next     = ctrl.irq_id;
    clear       = '0;
    case (state)
      IDLE: begin
        if (|active) begin
          state_next  = REQUEST;
          signal_next = 1'b1;
          id_next     = lowest_id;
        end
      end
      REQUEST: begin
        if (ctrl.isr_ack) begin
          state_next  = SERVICE;
          signal_next = 1'b0;
          clear       = NUM_IRQ'(1) << ctrl.irq_id;
        end
      end
      SERVICE: begin
        if (ctrl.isr_done) state_next = IDLE;
      end
      default: begin
        state_next  = IDLE;
        signal_next = 1'b0;
      end
    endcase
  end

  // A fresh edge on the bit being acknowledged keeps it pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      ctrl.interrupt_signal <= 1'b0;
      ctrl.irq_id           <= '0;
      pending               <= '0;
      irq_mask              <= '0;
    end else begin
      state                 <= state_next;
      ctrl.interrupt_signal <= signal_next;
      ctrl.irq_id           <= id_next;
      pending               <= (pending & ~clear) | rise;
      if (mask_wr_en) irq_mask <= mask_wr_data;
    end
  end

endmodule

// File: tb/tb_interrupt_request_unit.sv
// tb/tb_interrupt_request_unit.sv - self-checking bench for interrupt_request_unit
module tb_interrupt_request_unit;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic         mask_wr_en = 1'b0;
  logic [N-1:0] mask_wr_data = '0;
  logic [N-1:0] pending;
  logic [N-1:0] irq_mask;

  interrupt_request_unit_if #(.ID_W(3)) ctrl_bus ();

  interrupt_request_unit #(.NUM_IRQ(N), .ID_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .mask_wr_en   (mask_wr_en),
    .mask_wr_data (mask_wr_data),
    .pending      (pending),
    .irq_mask     (irq_mask),
    .ctrl         (ctrl_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge at sample N sets pending at edge N+2 unless reset intervenes.
  logic [N-1:0] h1 = '0, h2 = '0, h3 = '0;
  logic         r1 = 1'b1;
  logic [N-1:0] m_pend = '0, m_mask = '0;
  int           m_state = 0;
  logic         m_sig = 1'b0;
  int           m_id = 0;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    logic [N-1:0] sample;
    logic [N-1:0] set_bits;
    int           pick;
    sample   = reset ? '0 : irq_in;
    set_bits = r1 ? '0 : (h2 & ~h3);
    if (reset) begin
      m_pend = '0; m_mask = '0; m_state = 0; m_sig = 1'b0; m_id = 0;
    end else begin
      pick = lowest(m_pend & m_mask);
      case (m_state)
        0: if (pick >= 0) begin m_state = 1; m_sig = 1'b1; m_id = pick; end
        1: if (ctrl_bus.isr_ack) begin m_pend[m_id] = 1'b0; m_state = 2; m_sig = 1'b0; end
        default: if (ctrl_bus.isr_done) m_state = 0;
      endcase
      m_pend = m_pend | set_bits;
      if (mask_wr_en) m_mask = mask_wr_data;
    end
    h3 = h2; h2 = h1; h1 = sample; r1 = reset;
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model_interrupt_signal", 32'(ctrl_bus.interrupt_signal), 32'(m_sig));
      check("model_irq_id", 32'(ctrl_bus.irq_id), 32'(m_id));
      check("model_pending", 32'(pending), 32'(m_pend));
      check("model_irq_mask", 32'(irq_mask), 32'(m_mask));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_wr_en = 1'b1; mask_wr_data = v;
    tick();
    mask_wr_en = 1'b0;
  endtask

  task automatic ack_pulse();
    ctrl_bus.isr_ack = 1'b1; tick(); ctrl_bus.isr_ack = 1'b0;
  endtask

  task automatic done_pulse();
    ctrl_bus.isr_done = 1'b1; tick(); ctrl_bus.isr_done = 1'b0;
  endtask

  // Auto-responding controller; counts how many requests appear.
  task automatic respond(input int cycles, output int n_req, output int last_id);
    n_req = 0; last_id = -1;
    ctrl_bus.isr_done = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (ctrl_bus.interrupt_signal) begin n_req++; last_id = int'(ctrl_bus.irq_id); end
      ctrl_bus.isr_ack = ctrl_bus.interrupt_signal;
    end
    ctrl_bus.isr_ack = 1'b0; ctrl_bus.isr_done = 1'b0;
    tick();
  endtask

  initial begin
    int n_req;
    int last_id;
    ctrl_bus.isr_ack = 1'b0;
    ctrl_bus.isr_done = 1'b0;
    repeat (3) tick();
    checking = 1'b1;
    reset = 1'b0;
    check("reset_signal", 32'(ctrl_bus.interrupt_signal), 32'h0);
    check("reset_irq_id", 32'(ctrl_bus.irq_id), 32'h0);
    check("reset_pending", 32'(pending), 32'h0);
    check("reset_mask", 32'(irq_mask), 32'h0);

    // single pulse on line 3
    write_mask(8'hFF);
    irq_in[3] = 1'b1; tick(); irq_in[3] = 1'b0;
    tick(); tick();
    check("s1_pending_n2", 32'(pending), 32'h08);
    check("s1_signal_n2", 32'(ctrl_bus.interrupt_signal), 32'h0);
    tick();
    check("s1_signal_n3", 32'(ctrl_bus.interrupt_signal), 32'h1);
    check("s1_id", 32'(ctrl_bus.irq_id), 32'h3);
    ack_pulse();
    check("s1_pending_cleared", 32'(pending), 32'h0);
    check("s1_signal_dropped", 32'(ctrl_bus.interrupt_signal), 32'h0);
    done_pulse();

    // two lines together: lowest first
    irq_in = 8'h24;
    repeat (4) tick();
    check("s2_first_id", 32'(ctrl_bus.irq_id), 32'h2);
    check("s2_first_signal", 32'(ctrl_bus.interrupt_signal), 32'h1);
    check("s2_pending_both", 32'(pending), 32'h24);
    ack_pulse(); done_pulse(); tick();
    check("s2_second_id", 32'(ctrl_bus.irq_id), 32'h5);
    check("s2_second_signal", 32'(ctrl_bus.interrupt_signal), 32'h1);
    ack_pulse(); done_pulse();
    irq_in = '0;

    // masked line becomes pending, requests once unmasked
    write_mask(8'h00);
    irq_in[1] = 1'b1;
    repeat (4) tick();
    check("s3_pending_masked", 32'(pending), 32'h02);
    check("s3_no_request_masked", 32'(ctrl_bus.interrupt_signal), 32'h0);
    write_mask(8'h02);
    check("s3_no_request_mask_edge", 32'(ctrl_bus.interrupt_signal), 32'h0);
    tick();
    check("s3_request", 32'(ctrl_bus.interrupt_signal), 32'h1);
    check("s3_id", 32'(ctrl_bus.irq_id), 32'h1);
    ack_pulse(); done_pulse();
    irq_in = '0;

    // new edge on the acknowledged line coincides with isr_ack
    write_mask(8'hFF);
    irq_in[4] = 1'b1; tick(); irq_in[4] = 1'b0;
    repeat (3) tick();
    check("s4_request", 32'(ctrl_bus.irq_id), 32'h4);
    irq_in[4] = 1'b1; tick(); irq_in[4] = 1'b0; tick();
    ack_pulse();
    check("s4_set_wins", 32'(pending), 32'h10);
    check("s4_signal_dropped", 32'(ctrl_bus.interrupt_signal), 32'h0);
    done_pulse(); tick();
    check("s4_rerequest_signal", 32'(ctrl_bus.interrupt_signal), 32'h1);
    check("s4_rerequest_id", 32'(ctrl_bus.irq_id), 32'h4);
    ack_pulse(); done_pulse();

    // reset during SERVICE, then a stray isr_done
    irq_in[6] = 1'b1; tick(); irq_in[6] = 1'b0;
    repeat (3) tick();
    ack_pulse();
    check("s5_service_id_held", 32'(ctrl_bus.irq_id), 32'h6);
    reset = 1'b1; tick(); reset = 1'b0;
    check("s5_reset_signal", 32'(ctrl_bus.interrupt_signal), 32'h0);
    check("s5_reset_id", 32'(ctrl_bus.irq_id), 32'h0);
    check("s5_reset_pending", 32'(pending), 32'h0);
    check("s5_reset_mask", 32'(irq_mask), 32'h0);
    done_pulse();
    check("s5_stray_done", 32'(ctrl_bus.interrupt_signal), 32'h0);

    // held-high line produces one request
    write_mask(8'hFF);
    irq_in[0] = 1'b1;
    respond(20, n_req, last_id);
    check("s6_one_request", 32'(n_req), 32'h1);
    check("s6_id", 32'(last_id), 32'h0);
    irq_in = '0;
    tick();

    // line held high through reset release counts as one edge
    reset = 1'b1; irq_in[2] = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    write_mask(8'hFF);
    respond(15, n_req, last_id);
    check("s7_one_request", 32'(n_req), 32'h1);
    check("s7_id", 32'(last_id), 32'h2);
    irq_in = '0;
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) irq_in[b] = ~irq_in[b];
      mask_wr_en        = ($urandom_range(0, 19) == 0);
      mask_wr_data      = N'($urandom);
      ctrl_bus.isr_ack  = ($urandom_range(0, 3) == 0);
      ctrl_bus.isr_done = ($urandom_range(0, 3) == 0);
      reset             = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; mask_wr_en = 1'b0; irq_in = '0;
    ctrl_bus.isr_ack = 1'b0; ctrl_bus.isr_done = 1'b0;
    tick();
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_request_unit.md
INTERRUPT_REQUEST_UNIT -- requirements
Module: interrupt_request_unit

Interface
Parameters:
REQ-001 NUM_IRQ, 8, number of external interrupt lines (2..32).
REQ-002 ID_W, 3, width of irq_id; SHALL equal ceil(log2(NUM_IRQ)).
Ports:
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_in  input  NUM_IRQ  asynchronous external interrupt lines, level, active-high.
REQ-006 mask_wr_en  input  1  one-cycle strobe that loads mask_wr_data into the mask register.
REQ-007 mask_wr_data  input  NUM_IRQ  new mask value; bit=1 enables the line.
REQ-008 isr_ack  input  1  one-cycle pulse from the interrupt controller when it enters its ISR init state.
REQ-009 isr_done  input  1  one-cycle pulse from the interrupt controller on return-from-ISR.
REQ-010 interrupt_signal  output  1  registered request to the interrupt controller.
REQ-011 irq_id  output  ID_W  registered index of the line being requested or serviced.
REQ-012 pending  output  NUM_IRQ  registered pending-bit vector.
REQ-013 irq_mask  output  NUM_IRQ  registered current mask.

Function
REQ-014 Each irq_in bit SHALL pass through a 2-flop synchronizer, then a rising-edge detector comparing the synchronized value with its previous value.
REQ-015 A detected edge SHALL set the corresponding pending bit on the next rising edge; with irq_in high at sampling edge N, the pending bit is 1 after edge N+2.
REQ-016 Pending bits SHALL be set regardless of mask; masked lines SHALL NOT generate requests until unmasked.
REQ-017 FSM states: IDLE, REQUEST, SERVICE.
REQ-018 IDLE: if (pending & irq_mask) != 0, latch irq_id = lowest set index, assert interrupt_signal, go to REQUEST on the same edge; otherwise stay.
REQ-019 REQUEST: hold interrupt_signal and irq_id stable; on isr_ack, clear pending[irq_id], deassert interrupt_signal, go to SERVICE.
REQ-020 SERVICE: interrupt_signal stays 0; on isr_done go to IDLE; irq_id holds until the next request is latched.
REQ-021 Request latency: interrupt_signal SHALL be 1 after edge N+3 for irq_in first sampled high at edge N, in IDLE with the line unmasked.
REQ-022 Simultaneous clear (isr_ack) and new edge on the same bit: set wins; the bit remains pending.
REQ-023 Unmasking a line during REQUEST SHALL NOT change irq_id; masking the requested line during REQUEST SHALL NOT withdraw interrupt_signal.
REQ-024 isr_ack outside REQUEST and isr_done outside SERVICE SHALL be ignored.
REQ-025 isr_ack and isr_done in the same cycle while in REQUEST: only isr_ack is acted on; the FSM enters SERVICE.
REQ-026 A held-high irq_in SHALL produce exactly one pending set; another requires a low-to-high transition.
REQ-027 mask_wr_en SHALL update irq_mask on the next edge in any state.

Reset
REQ-028 On reset, pending = 0, irq_mask = 0, interrupt_signal = 0, irq_id = 0, FSM = IDLE; synchronizer and edge-history flops = 0.
REQ-029 Reset asserted mid-REQUEST or mid-SERVICE SHALL discard the in-flight request; no isr_ack or isr_done is expected afterward.
REQ-030 irq_in held high through reset deassertion SHALL register as one edge after reset.

Structure
REQ-031 FSM state encodings (IDLE=0, REQUEST=1, SERVICE=2, 2 bits) SHALL live in a shared package/header alongside the interrupt controller's state constants.
REQ-032 Synchronizer plus edge detector SHALL be one sub-module, irq_sync_edge (1 bit), instantiated NUM_IRQ times.
REQ-033 Priority encoding (lowest index wins) SHALL be combinational inside interrupt_request_unit.

Verification
REQ-034 Mask=0xFF, pulse irq_in[3] high at edge N -> interrupt_signal=1, irq_id=3 after edge N+3; isr_ack -> pending[3]=0, signal=0.
REQ-035 Mask=0xFF, irq_in[5] and irq_in[2] rise together -> irq_id=2 first; after ack+done -> second request irq_id=5.
REQ-036 Mask=0x00, irq_in[1] rises -> pending=0x02, interrupt_signal stays 0; write mask=0x02 -> request irq_id=1 two edges later.
REQ-037 In REQUEST for id 4, new edge on irq_in[4] coincides with isr_ack -> pending[4] stays 1; re-request after isr_done.
REQ-038 Reset pulsed during SERVICE -> all outputs 0, FSM IDLE next cycle; stray isr_done is ignored.
REQ-039 irq_in[0] held high for 20 cycles -> exactly one request issued.
